complex_dot_product_engine: RTL and testbench
=============================================

COMPLEX_DOT_PRODUCT_ENGINE -- requirements
Module: complex_dot_product_engine

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, sample width per real/imag part; ADDR_WIDTH, 3, RAM address width; DEPTH, 8, vector length, 1..2^ADDR_WIDTH; ACC_WIDTH, 2*WIDTH+ADDR_WIDTH+1, accumulator width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one dot-product pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle completion pulse.
- readAddrReal / readAddrImag  out  ADDR_WIDTH each  RAM-bank read addresses, always equal.
- din_aReal, din_aImag, din_bReal, din_bImag, din_cReal, din_cImag, din_dReal, din_dImag  in  WIDTH each  RAM-bank read data, signed.
- dotAB_real, dotAB_imag, dotCD_real, dotCD_imag  out  ACC_WIDTH each  signed results.

Function
REQ-004 The block SHALL compute sum over k=0..DEPTH-1 of a[k]*b[k] on the AB outputs and of c[k]*d[k] on the CD outputs, using signed complex multiplication:
- real = xr*yr - xi*yi
- imag = xr*yi + xi*yr
REQ-005 RAM read latency SHALL be one cycle: data for an address presented in cycle n is sampled in cycle n+1.
REQ-006 The FSM SHALL have states IDLE, READ, DRAIN, DONE.
- IDLE -> READ on start=1.
- READ -> DRAIN after address DEPTH-1 is issued.
- DRAIN -> DONE after two cycles.
- DONE -> IDLE after one cycle.
REQ-007 On the edge that samples start in IDLE, all four accumulators SHALL clear to 0 and the address counter SHALL load 0.
REQ-008 In READ the address SHALL increment by 1 per cycle from 0 to DEPTH-1, with no wrap; in every other state the address SHALL be 0.
REQ-009 Pipeline: address cycle -> RAM data cycle -> registered products -> accumulate; results SHALL be final when done=1.
REQ-010 done SHALL be 1 for exactly one cycle, DEPTH+3 cycles after the start-sampling edge.
REQ-011 busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-012 start SHALL be ignored while busy=1, with no restart and no accumulator clear.
REQ-013 Result outputs SHALL hold their value from done until the next accepted start.
REQ-014 Products SHALL be sign-extended to ACC_WIDTH before summing; ACC_WIDTH SHALL be sized so accumulation never overflows, including the case of all inputs equal to -2^(WIDTH-1).

Reset
REQ-015 While rst_n=0, the block SHALL hold state IDLE with busy=0, done=0, address=0, all results=0 and product registers=0, asynchronously.
REQ-016 Reset asserted mid-pass SHALL abort the pass and produce no done pulse; the first start after release SHALL run a full pass.

Configuration
REQ-017 The macro DOTPROD_CONJ_EN SHALL select the second operand of each product.
- Defined: conjugate the second operand, computing a*conj(b) and c*conj(d): real = xr*yr + xi*yi, imag = xi*yr - xr*yi.
- Undefined: plain products per REQ-004.
- Latency and interface SHALL be identical in both builds.

Structure
REQ-018 Package dot_product_pkg SHALL hold the FSM state type, the DRAIN cycle count constant and the ACC_WIDTH derivation.
REQ-019 One sub-module complex_mac (one multiply register plus one accumulator for one complex lane) SHALL be instantiated twice, for AB and CD; the FSM and address counter SHALL live in the top level.

Verification
REQ-020 The bench SHALL cover these scenarios:
- All a=b=c=d=1+0j, DEPTH=8, one start -> dotAB = dotCD = 8+0j; done exactly 11 cycles after the start edge; addresses 0..7, one per cycle.
- a=b=0+1j at all entries -> dotAB = -8+0j without DOTPROD_CONJ_EN and +8+0j with it.
- a[k]=k+0j, b[k]=0+2j, k=0..7 -> dotAB = 0+56j.
- All parts = -32768 -> dotAB real = 0, imag = 2^34; no overflow.
- start pulsed in cycle 3 of an active pass -> ignored; single done; results unchanged.
- rst_n low in cycle 4 of a pass -> busy=0, outputs 0, no done; next start -> correct result.

Source files
------------

// File: rtl/dot_product_pkg.sv
// ---------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the complex dot-product engine:
//   state_t       - controller FSM state encoding
//   DRAIN_CYCLES  - cycles spent flushing the RAM/product pipeline after the
//                   last address has been issued
//   acc_width()   - accumulator width so that DEPTH worst-case products
//                   (all parts = -2^(WIDTH-1)) can be summed without overflow
// ---------------------------------------------------------------------------
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One cycle for the RAM read of the last address plus one for its product.
  localparam int DRAIN_CYCLES = 2;

  // A complex product part needs 2*w+1 bits; summing up to 2^aw of them
  // needs aw more bits.
  function automatic int acc_width(input int w, input int aw);
    return 2 * w + aw + 1;
  endfunction

endpackage

// File: rtl/complex_mac.sv
// ---------------------------------------------------------------------------
// complex_mac
// One complex multiply-accumulate lane: a registered complex product followed
// by a complex accumulator.
// Macro: DOTPROD_CONJ_EN - when defined the second operand is conjugated
//   (x * conj(y)); otherwise x * y. Timing is identical in both builds.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              zero the accumulators (has priority over acc_en)
//   mul_en             capture the product of the current operands
//   acc_en             add the registered product into the accumulators
//   xr, xi, yr, yi     signed operand parts
//   acc_real, acc_imag signed accumulated result
// ---------------------------------------------------------------------------
module complex_mac #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        mul_en,
  input  logic                        acc_en,
  input  logic signed [WIDTH-1:0]     xr,
  input  logic signed [WIDTH-1:0]     xi,
  input  logic signed [WIDTH-1:0]     yr,
  input  logic signed [WIDTH-1:0]     yi,
  output logic signed [ACC_WIDTH-1:0] acc_real,
  output logic signed [ACC_WIDTH-1:0] acc_imag
);

  localparam int MW = 2 * WIDTH;
  localparam int PW = 2 * WIDTH + 1;

  logic signed [MW-1:0] xr_w, xi_w, yr_w, yi_w;
  logic signed [MW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0] prod_real_next, prod_imag_next;
  logic signed [PW-1:0] prod_real, prod_imag;

  // Operands widened first so every partial product is computed at full width.
  assign xr_w = {{WIDTH{xr[WIDTH-1]}}, xr};
  assign xi_w = {{WIDTH{xi[WIDTH-1]}}, xi};
  assign yr_w = {{WIDTH{yr[WIDTH-1]}}, yr};
  assign yi_w = {{WIDTH{yi[WIDTH-1]}}, yi};

  assign rr = xr_w * yr_w;
  assign ii = xi_w * yi_w;
  assign ri = xr_w * yi_w;
  assign ir = xi_w * yr_w;

  // The extra bit covers (-2^(W-1))^2 + (-2^(W-1))^2 = 2^(2W-1).
  always_comb begin
    prod_real_next = '0;
    prod_imag_next = '0;
`ifdef DOTPROD_CONJ_EN
    prod_real_next = {rr[MW-1], rr} + {ii[MW-1], ii};
    prod_imag_next = {ir[MW-1], ir} - {ri[MW-1], ri};
`else
    prod_real_next = {rr[MW-1], rr} - {ii[MW-1], ii};
    prod_imag_next = {ri[MW-1], ri} + {ir[MW-1], ir};
`endif
  end

  // Product register then accumulator; products are sign-extended before summing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_real <= '0;
      prod_imag <= '0;
      acc_real  <= '0;
      acc_imag  <= '0;
    end else begin
      if (mul_en) begin
        prod_real <= prod_real_next;
        prod_imag <= prod_imag_next;
      end
      if (clear) begin
        acc_real <= '0;
        acc_imag <= '0;
      end else if (acc_en) begin
        acc_real <= acc_real + {{(ACC_WIDTH-PW){prod_real[PW-1]}}, prod_real};
        acc_imag <= acc_imag + {{(ACC_WIDTH-PW){prod_imag[PW-1]}}, prod_imag};
      end
    end
  end

endmodule

// File: rtl/complex_dot_product_engine.sv
// ---------------------------------------------------------------------------
// complex_dot_product_engine
// Computes sum(a[k]*b[k]) and sum(c[k]*d[k]), k = 0..DEPTH-1, over complex
// samples read from eight external RAM banks with one-cycle read latency.
// Macro: DOTPROD_CONJ_EN (see complex_mac) conjugates b and d.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start                          request a pass (ignored while busy)
//   busy                           pass in progress
//   done                           one-cycle pulse when results are final
//   readAddrReal, readAddrImag     RAM read address (always equal)
//   din_{a,b,c,d}{Real,Imag}       RAM read data, signed
//   dotAB_*, dotCD_*               signed results, held until next start
// Pipeline: address (cycle n) -> RAM data (n+1) -> product reg -> accumulate.
// ---------------------------------------------------------------------------
module complex_dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = acc_width(WIDTH, ADDR_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       readAddrReal,
  output logic [ADDR_WIDTH-1:0]       readAddrImag,
  input  logic signed [WIDTH-1:0]     din_aReal,
  input  logic signed [WIDTH-1:0]     din_aImag,
  input  logic signed [WIDTH-1:0]     din_bReal,
  input  logic signed [WIDTH-1:0]     din_bImag,
  input  logic signed [WIDTH-1:0]     din_cReal,
  input  logic signed [WIDTH-1:0]     din_cImag,
  input  logic signed [WIDTH-1:0]     din_dReal,
  input  logic signed [WIDTH-1:0]     din_dImag,
  output logic signed [ACC_WIDTH-1:0] dotAB_real,
  output logic signed [ACC_WIDTH-1:0] dotAB_imag,
  output logic signed [ACC_WIDTH-1:0] dotCD_real,
  output logic signed [ACC_WIDTH-1:0] dotCD_imag
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0]            LAST_DRAIN = 2'(DRAIN_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            drain_cnt;
  logic                  data_valid;
  logic                  prod_valid;
  logic                  clear;

  assign readAddrReal = addr;
  assign readAddrImag = addr;

  // Accumulators clear on the same edge that accepts start.
  assign clear = (state == IDLE) && start;

  // Controller: state, address counter, pipeline valid flags, busy/done.
  // data_valid marks the cycle RAM data for a READ-cycle address is present;
  // prod_valid marks the cycle after that, when the product register holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      drain_cnt  <= '0;
      data_valid <= 1'b0;
      prod_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_valid <= (state == READ);
      prod_valid <= data_valid;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (addr == LAST_ADDR) begin
            state     <= DRAIN;
            addr      <= '0;
            drain_cnt <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  complex_mac #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac_ab (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mul_en   (data_valid),
    .acc_en   (prod_valid),
    .xr       (din_aReal),
    .xi       (din_aImag),
    .yr       (din_bReal),
    .yi       (din_bImag),
    .acc_real (dotAB_real),
    .acc_imag (dotAB_imag)
  );

  complex_mac #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac_cd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .mul_en   (data_valid),
    .acc_en   (prod_valid),
    .xr       (din_cReal),
    .xi       (din_cImag),
    .yr       (din_dReal),
    .yi       (din_dImag),
    .acc_real (dotCD_real),
    .acc_imag (dotCD_imag)
  );

endmodule

// File: tb/tb_complex_dot_product_engine.sv
// ---------------------------------------------------------------------------
// tb_complex_dot_product_engine
// Directed vectors with hand-computed results. Each pass pushes its expected
// results into a queue; a monitor pops and compares whenever done is seen.
// Cycle numbering: cycle 1 is the cycle right after the edge that samples
// start; done is expected in cycle DEPTH+3 = 11.
// Build with +define+DOTPROD_CONJ_EN to check the conjugating variant.
// ---------------------------------------------------------------------------
module tb_complex_dot_product_engine;

  localparam int WIDTH      = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 8;
  localparam int ACC_WIDTH  = 2 * WIDTH + ADDR_WIDTH + 1;
  localparam int NO_RESTART = -10;

  typedef struct {
    string  name;
    longint ab_r;
    longint ab_i;
    longint cd_r;
    longint cd_i;
  } expect_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [ADDR_WIDTH-1:0] readAddrReal, readAddrImag;
  logic signed [WIDTH-1:0] din_aReal, din_aImag, din_bReal, din_bImag;
  logic signed [WIDTH-1:0] din_cReal, din_cImag, din_dReal, din_dImag;
  logic signed [ACC_WIDTH-1:0] dotAB_real, dotAB_imag, dotCD_real, dotCD_imag;

  logic signed [WIDTH-1:0] mem_ar [DEPTH];
  logic signed [WIDTH-1:0] mem_ai [DEPTH];
  logic signed [WIDTH-1:0] mem_br [DEPTH];
  logic signed [WIDTH-1:0] mem_bi [DEPTH];
  logic signed [WIDTH-1:0] mem_cr [DEPTH];
  logic signed [WIDTH-1:0] mem_ci [DEPTH];
  logic signed [WIDTH-1:0] mem_dr [DEPTH];
  logic signed [WIDTH-1:0] mem_di [DEPTH];

  expect_t exp_q[$];
  int cmp_count  = 0;
  int fail_count = 0;
  int done_count = 0;

  complex_dot_product_engine #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .readAddrReal (readAddrReal),
    .readAddrImag (readAddrImag),
    .din_aReal    (din_aReal),
    .din_aImag    (din_aImag),
    .din_bReal    (din_bReal),
    .din_bImag    (din_bImag),
    .din_cReal    (din_cReal),
    .din_cImag    (din_cImag),
    .din_dReal    (din_dReal),
    .din_dImag    (din_dImag),
    .dotAB_real   (dotAB_real),
    .dotAB_imag   (dotAB_imag),
    .dotCD_real   (dotCD_real),
    .dotCD_imag   (dotCD_imag)
  );

  always #5 clk = ~clk;

  // RAM banks with one-cycle read latency.
  always @(posedge clk) begin
    din_aReal <= mem_ar[readAddrReal];
    din_aImag <= mem_ai[readAddrImag];
    din_bReal <= mem_br[readAddrReal];
    din_bImag <= mem_bi[readAddrImag];
    din_cReal <= mem_cr[readAddrReal];
    din_cImag <= mem_ci[readAddrImag];
    din_dReal <= mem_dr[readAddrReal];
    din_dImag <= mem_di[readAddrImag];
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    cmp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected result set.
  always @(negedge clk) begin
    expect_t e;
    if (rst_n && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        cmp_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_done: got a done pulse, required none (no pass pending)");
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_ab_real"}, longint'(dotAB_real), e.ab_r);
        checkOutput({e.name, "_ab_imag"}, longint'(dotAB_imag), e.ab_i);
        checkOutput({e.name, "_cd_real"}, longint'(dotCD_real), e.cd_r);
        checkOutput({e.name, "_cd_imag"}, longint'(dotCD_imag), e.cd_i);
      end
    end
  end

  task automatic fillAll(input int ar, input int ai, input int br, input int bi,
                         input int cr, input int ci, input int dr, input int di);
    for (int k = 0; k < DEPTH; k++) begin
      mem_ar[k] = WIDTH'(ar);
      mem_ai[k] = WIDTH'(ai);
      mem_br[k] = WIDTH'(br);
      mem_bi[k] = WIDTH'(bi);
      mem_cr[k] = WIDTH'(cr);
      mem_ci[k] = WIDTH'(ci);
      mem_dr[k] = WIDTH'(dr);
      mem_di[k] = WIDTH'(di);
    end
  endtask

  // Runs one pass: queues the expectation, pulses start, optionally checks the
  // address sequence and busy, and optionally re-pulses start mid-pass.
  task automatic applyStimulus(input string name, input longint ab_r, input longint ab_i,
                               input longint cd_r, input longint cd_i,
                               input bit check_addr, input int restart_cycle);
    int cycles;
    expect_t e;
    e.name = name;
    e.ab_r = ab_r;
    e.ab_i = ab_i;
    e.cd_r = cd_r;
    e.cd_i = cd_i;
    exp_q.push_back(e);
    cycles = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == restart_cycle) start = 1'b1;
      if (i == restart_cycle + 1) start = 1'b0;
      if (check_addr) begin
        if (i <= DEPTH) begin
          checkOutput($sformatf("%s_addr_real_c%0d", name, i), longint'(readAddrReal), longint'(i - 1));
          checkOutput($sformatf("%s_addr_imag_c%0d", name, i), longint'(readAddrImag), longint'(i - 1));
        end else begin
          checkOutput($sformatf("%s_addr_idle_c%0d", name, i), longint'(readAddrReal), 0);
        end
        checkOutput($sformatf("%s_busy_c%0d", name, i), longint'(busy), 1);
      end
      if (done) begin
        cycles = i;
        break;
      end
    end
    checkOutput({name, "_done_latency"}, longint'(cycles), longint'(DEPTH + 3));
    @(negedge clk);
    checkOutput({name, "_done_single_cycle"}, longint'(done), 0);
    checkOutput({name, "_busy_after_done"}, longint'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    fillAll(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_addr", longint'(readAddrReal), 0);
    checkOutput("reset_ab_real", longint'(dotAB_real), 0);
    checkOutput("reset_cd_imag", longint'(dotCD_imag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all ones -> 8+0j on both lanes, with address/latency checks
    $display("[TB] test ones");
    fillAll(1, 0, 1, 0, 1, 0, 1, 0);
    applyStimulus("ones", 8, 0, 8, 0, 1'b1, NO_RESTART);
    repeat (3) @(negedge clk);
    checkOutput("ones_hold_ab_real", longint'(dotAB_real), 8);
    checkOutput("ones_hold_cd_real", longint'(dotCD_real), 8);

    // 2: a=b=j; c=1+j, d=1-j
    $display("[TB] test imag");
    fillAll(0, 1, 0, 1, 1, 1, 1, -1);
`ifdef DOTPROD_CONJ_EN
    applyStimulus("imag", 8, 0, 0, 16, 1'b0, NO_RESTART);
`else
    applyStimulus("imag", -8, 0, 16, 0, 1'b0, NO_RESTART);
`endif

    // 3: a[k]=k, b=2j; c=1+j, d[k]=k
    $display("[TB] test ramp");
    fillAll(0, 0, 0, 2, 1, 1, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      mem_ar[k] = WIDTH'(k);
      mem_dr[k] = WIDTH'(k);
    end
`ifdef DOTPROD_CONJ_EN
    applyStimulus("ramp", 0, -56, 28, 28, 1'b0, NO_RESTART);
`else
    applyStimulus("ramp", 0, 56, 28, 28, 1'b0, NO_RESTART);
`endif

    // 4: start re-pulsed in cycle 3 must be ignored; same data as ramp
    $display("[TB] test restart ignored");
    dc = done_count;
`ifdef DOTPROD_CONJ_EN
    applyStimulus("restart", 0, -56, 28, 28, 1'b0, 3);
`else
    applyStimulus("restart", 0, 56, 28, 28, 1'b0, 3);
`endif
    repeat (15) @(negedge clk);
    checkOutput("restart_single_done", longint'(done_count - dc), 1);
    checkOutput("restart_busy_idle", longint'(busy), 0);

    // 5: full-scale negative inputs -> no overflow
    $display("[TB] test fullscale");
    fillAll(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
`ifdef DOTPROD_CONJ_EN
    applyStimulus("fullscale", 64'd17179869184, 0, 64'd17179869184, 0, 1'b0, NO_RESTART);
`else
    applyStimulus("fullscale", 0, 64'd17179869184, 0, 64'd17179869184, 1'b0, NO_RESTART);
`endif

    // 6: reset in cycle 4 aborts the pass; accumulators already hold 1 by then
    $display("[TB] test abort");
    fillAll(1, 0, 1, 0, 1, 0, 1, 0);
    dc = done_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", longint'(busy), 0);
    checkOutput("abort_done", longint'(done), 0);
    checkOutput("abort_addr", longint'(readAddrReal), 0);
    checkOutput("abort_ab_real", longint'(dotAB_real), 0);
    checkOutput("abort_cd_real", longint'(dotCD_real), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", longint'(done_count - dc), 0);
    applyStimulus("after_abort", 8, 0, 8, 0, 1'b0, NO_RESTART);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
